line_mem_bridge: RTL and testbench

LINE_MEM_BRIDGE -- requirements
Module: line_mem_bridge

---
 rtl/line_mem_bridge_pkg.sv | 30 +++
 rtl/line_mem_bridge_if.sv | 43 ++++
 rtl/line_mem_bridge.sv | 98 +++++++++
 tb/tb_line_mem_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_bridge_pkg
// Brief    : Shared line/word geometry and bridge state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package line_mem_bridge_pkg;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = WORD_W * LINE_WORDS;
    localparam int ADDR_W     = 8;
    localparam int WORD_IDX_W = $clog2(LINE_WORDS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] W_DONE = 3'd3;
    localparam logic [2:0] R_DONE = 3'd4;

    // Word address within a line: the index replaces the low bits, never carries.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-WORD_IDX_W-1:0] base,
        input logic [WORD_IDX_W-1:0]        idx
    );
        return {base, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_bridge_if
// Brief    : Cache-side line requests and word-RAM bus of the line bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface line_mem_bridge_if import line_mem_bridge_pkg::*; ();

    logic              dr_valid;
    logic [ADDR_W-1:0] dr_addr;
    logic              dr_ready;
    logic [LINE_W-1:0] dr_line;

    logic              dw_valid;
    logic [ADDR_W-1:0] dw_addr;
    logic [LINE_W-1:0] dw_line;
    logic              dw_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    // Bridge view
    modport slave (
        input  dr_valid, dr_addr, dw_valid, dw_addr, dw_line, mem_rdata,
        output dr_ready, dr_line, dw_ready, mem_addr, mem_we, mem_wdata
    );

    // Cache view
    modport master (
        output dr_valid, dr_addr, dw_valid, dw_addr, dw_line,
        input  dr_ready, dr_line, dw_ready
    );

    // Word RAM view
    modport mem (
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/line_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_bridge
// Brief    : Moves 4-word cache lines to/from a word RAM with WAIT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module line_mem_bridge import line_mem_bridge_pkg::*; #(
    parameter int WAIT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    line_mem_bridge_if.slave bus
);

    localparam logic [4:0] c_wr_last = 5'(WAIT);
    localparam logic [4:0] c_rd_last = 5'(WAIT + 1);

    logic [2:0]                         r_state;
    logic [WORD_IDX_W-1:0]              r_word;
    logic [4:0]                         r_cyc;
    logic [ADDR_W-WORD_IDX_W-1:0]       r_base;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  r_line;
    logic [LINE_WORDS-2:0][WORD_W-1:0]  r_buf;
    logic [LINE_W-1:0]                  r_dr_line;

    logic w_busy;
    logic w_unused;

    assign w_busy   = (r_state == WRITE) || (r_state == READ);
    assign w_unused = &{1'b0, bus.dr_addr[1:0], bus.dw_addr[1:0]};

    assign bus.mem_addr  = w_busy ? word_addr(r_base, r_word) : '0;
    assign bus.mem_we    = (r_state == WRITE) && (r_cyc == 5'd0);
    assign bus.mem_wdata = (r_state == WRITE) ? r_line[r_word] : '0;
    assign bus.dw_ready  = (r_state == W_DONE);
    assign bus.dr_ready  = (r_state == R_DONE);
    assign bus.dr_line   = r_dr_line;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_cyc     <= '0;
            r_base    <= '0;
            r_line    <= '0;
            r_buf     <= '0;
            r_dr_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_word <= '0;
                    r_cyc  <= '0;
                    if (bus.dw_valid) begin
                        r_state <= WRITE;
                        r_base  <= bus.dw_addr[ADDR_W-1:WORD_IDX_W];
                        r_line  <= bus.dw_line;
                    end else if (bus.dr_valid) begin
                        r_state <= READ;
                        r_base  <= bus.dr_addr[ADDR_W-1:WORD_IDX_W];
                    end
                end
                // Strobe on r_cyc==0, then WAIT idle cycles with the address held.
                WRITE: begin
                    if (r_cyc == c_wr_last) begin
                        r_cyc <= '0;
                        if (r_word == 2'd3) begin
                            r_state <= W_DONE;
                        end else begin
                            r_word <= r_word + 2'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 5'd1;
                    end
                end
                // RAM data is valid from the second cycle of the window onward.
                READ: begin
                    if (r_cyc == c_rd_last) begin
                        r_cyc <= '0;
                        if (r_word == 2'd3) begin
                            r_state   <= R_DONE;
                            r_dr_line <= {bus.mem_rdata, r_buf};
                        end else begin
                            r_buf[r_word] <= bus.mem_rdata;
                            r_word        <= r_word + 2'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 5'd1;
                    end
                end
                W_DONE:  r_state <= IDLE;
                R_DONE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_mem_bridge
// Brief    : Directed bench for line_mem_bridge at WAIT=2 and WAIT=0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

module tb_line_mem_bridge;
    import line_mem_bridge_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    line_mem_bridge_if bus ();
    line_mem_bridge_if bus0 ();

    line_mem_bridge #(.WAIT(2)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
    line_mem_bridge #(.WAIT(0)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));

    mem_word_ram ram  (.clk(clk), .we(bus.mem_we),  .addr(bus.mem_addr),
                       .wdata(bus.mem_wdata),  .rdata(bus.mem_rdata));
    mem_word_ram ram0 (.clk(clk), .we(bus0.mem_we), .addr(bus0.mem_addr),
                       .wdata(bus0.mem_wdata), .rdata(bus0.mem_rdata));

    localparam logic [127:0] c_line_a = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    localparam logic [127:0] c_line_d = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    localparam logic [127:0] c_line_p = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    localparam logic [127:0] c_line_e = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.mem_addr !== 8'h00 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: addr=%h we=%b wdata=%h want 00/0/0", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        total++;
        if (bus.dr_ready !== 1'b0 || bus.dw_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: dr=%b dw=%b want 0/0", bus.dr_ready, bus.dw_ready);
        end
        total++;
        if (bus.dr_line !== 128'h0 || bus0.dr_line !== 128'h0) begin
            bad++;
            $display("FAIL reset_line: %h / %h want 0", bus.dr_line, bus0.dr_line);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int done = 0;
        int addr_bad = 0;
        int we_seen = 0;
        logic [127:0] line = '0;
        logic [7:0] exp_a;
        logic after_rdy = 1'b1;
        logic [7:0] after_addr = 8'hxx;
        for (int k = 0; k < 4; k++) ram.mem[8 + k] = c_line_a[32*k +: 32];
        bus.dr_addr  = 8'h0A;
        bus.dr_valid = 1'b1;
        tick();
        bus.dr_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) bus.dr_addr = 8'h55;
            exp_a = 8'h08 + 8'((c - 1) / 4);
            if (c <= 16 && bus.mem_addr !== exp_a) addr_bad++;
            if (bus.mem_we !== 1'b0) we_seen++;
            if (done != 0 && c == done + 1) begin
                after_rdy  = bus.dr_ready;
                after_addr = bus.mem_addr;
                break;
            end
            if (done == 0 && bus.dr_ready === 1'b1) begin
                done = c;
                line = bus.dr_line;
            end
            tick();
        end
        total++;
        if (addr_bad != 0) begin bad++; $display("FAIL read_addr: %0d bad cycles want 0", addr_bad); end
        total++;
        if (we_seen != 0) begin bad++; $display("FAIL read_we: %0d we cycles want 0", we_seen); end
        total++;
        if (done != 17) begin bad++; $display("FAIL read_latency: cycle %0d want 17", done); end
        total++;
        if (line !== c_line_a) begin bad++; $display("FAIL read_line: %h want %h", line, c_line_a); end
        total++;
        if (after_rdy !== 1'b0 || after_addr !== 8'h00) begin
            bad++;
            $display("FAIL read_after: rdy=%b addr=%h want 0/00", after_rdy, after_addr);
        end
        bus.dr_addr = 8'h00;
    endtask

    task automatic test_write();
        int np = 0;
        int done = 0;
        int rd_seen = 0;
        int addr_bad = 0;
        int idle_bad = 0;
        int wc [4];
        logic [7:0] wa [4];
        logic [31:0] wd [4];
        logic [7:0] exp_a;
        for (int k = 0; k < 4; k++) begin wc[k] = 0; wa[k] = 8'h00; wd[k] = 32'h0; end
        bus.dw_addr  = 8'h20;
        bus.dw_line  = c_line_d;
        bus.dw_valid = 1'b1;
        tick();
        bus.dw_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) begin bus.dw_addr = 8'h77; bus.dw_line = '1; end
            if (c == 5) bus.dr_valid = 1'b1;
            if (c == 10) bus.dr_valid = 1'b0;
            exp_a = 8'h20 + 8'((c - 1) / 3);
            if (c <= 12 && bus.mem_addr !== exp_a) addr_bad++;
            if (bus.mem_we === 1'b1) begin
                if (np < 4) begin wc[np] = c; wa[np] = bus.mem_addr; wd[np] = bus.mem_wdata; end
                np++;
            end
            if (bus.dr_ready !== 1'b0) rd_seen++;
            if (done != 0 && c > done && (bus.mem_addr !== 8'h00 || bus.dw_ready !== 1'b0)) idle_bad++;
            if (done == 0 && bus.dw_ready === 1'b1) done = c;
            if (done != 0 && c == done + 3) break;
            tick();
        end
        total++;
        if (np != 4) begin bad++; $display("FAIL write_pulses: %0d want 4", np); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (wc[k] != 1 + 3 * k || wa[k] !== 8'(8'h20 + k) || wd[k] !== c_line_d[32*k +: 32]) begin
                bad++;
                $display("FAIL write_word%0d: cyc=%0d addr=%h data=%h want %0d/%h/%h",
                         k, wc[k], wa[k], wd[k], 1 + 3 * k, 8'(8'h20 + k), c_line_d[32*k +: 32]);
            end
        end
        total++;
        if (addr_bad != 0) begin bad++; $display("FAIL write_addr_hold: %0d bad cycles want 0", addr_bad); end
        total++;
        if (done != 13) begin bad++; $display("FAIL write_latency: cycle %0d want 13", done); end
        total++;
        if (rd_seen != 0 || idle_bad != 0) begin
            bad++;
            $display("FAIL write_ignore_dr: rd=%0d idle_bad=%0d want 0/0", rd_seen, idle_bad);
        end
        total++;
        if ({ram.mem[35], ram.mem[34], ram.mem[33], ram.mem[32]} !== c_line_d) begin
            bad++;
            $display("FAIL write_ram: %h want %h", {ram.mem[35], ram.mem[34], ram.mem[33], ram.mem[32]}, c_line_d);
        end
        total++;
        if (bus.dr_line !== c_line_a) begin bad++; $display("FAIL write_keeps_drline: %h want %h", bus.dr_line, c_line_a); end
        bus.dw_addr = 8'h00;
        bus.dw_line = '0;
    endtask

    task automatic test_back_to_back();
        int done = 0;
        int rc;
        bus.dw_addr  = 8'h40;
        bus.dw_line  = c_line_p;
        bus.dr_addr  = 8'h20;
        bus.dw_valid = 1'b1;
        bus.dr_valid = 1'b1;
        tick();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h40) begin
            bad++;
            $display("FAIL prio_first: we=%b addr=%h want 1/40", bus.mem_we, bus.mem_addr);
        end
        bus.dw_valid = 1'b0;
        bus.dr_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (bus.dw_ready === 1'b1) begin done = c; break; end
            tick();
        end
        total++;
        if (done != 13) begin bad++; $display("FAIL prio_wb_latency: cycle %0d want 13", done); end
        tick();
        bus.dr_valid = 1'b1;
        tick();
        total++;
        if (bus.mem_addr !== 8'h20 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL b2b_read_start: addr=%h we=%b want 20/0", bus.mem_addr, bus.mem_we);
        end
        bus.dr_valid = 1'b0;
        rc = 1;
        while (rc <= 30 && bus.dr_ready !== 1'b1) begin tick(); rc++; end
        total++;
        if (rc != 17 || bus.dr_line !== c_line_d) begin
            bad++;
            $display("FAIL b2b_read: cycle %0d line %h want 17 %h", rc, bus.dr_line, c_line_d);
        end
        total++;
        if ({ram.mem[67], ram.mem[66], ram.mem[65], ram.mem[64]} !== c_line_p) begin
            bad++;
            $display("FAIL prio_ram: %h want %h", {ram.mem[67], ram.mem[66], ram.mem[65], ram.mem[64]}, c_line_p);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int rdy_seen = 0;
        int addr_bad = 0;
        int rc;
        bus.dr_addr  = 8'h08;
        bus.dr_valid = 1'b1;
        tick();
        bus.dr_valid = 1'b0;
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        total++;
        if (bus.mem_addr !== 8'h00 || bus.mem_we !== 1'b0 || bus.dr_line !== 128'h0 || bus.dr_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: addr=%h we=%b rdy=%b line=%h want zeros",
                     bus.mem_addr, bus.mem_we, bus.dr_ready, bus.dr_line);
        end
        rstn = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.dr_ready !== 1'b0) rdy_seen++;
            if (bus.mem_addr !== 8'h00) addr_bad++;
        end
        total++;
        if (rdy_seen != 0 || addr_bad != 0) begin
            bad++;
            $display("FAIL abort_no_done: rdy=%0d addr_bad=%0d want 0/0", rdy_seen, addr_bad);
        end
        bus.dr_addr  = 8'h0B;
        bus.dr_valid = 1'b1;
        tick();
        bus.dr_valid = 1'b0;
        rc = 1;
        while (rc <= 30 && bus.dr_ready !== 1'b1) begin tick(); rc++; end
        total++;
        if (rc != 17 || bus.dr_line !== c_line_a) begin
            bad++;
            $display("FAIL abort_recover: cycle %0d line %h want 17 %h", rc, bus.dr_line, c_line_a);
        end
        tick();
    endtask

    task automatic test_wait0();
        int done = 0;
        int addr_bad = 0;
        int np = 0;
        int we_bad = 0;
        logic [7:0] exp_a;
        for (int k = 0; k < 4; k++) ram0.mem[252 + k] = c_line_e[32*k +: 32];
        bus0.dr_addr  = 8'hFC;
        bus0.dr_valid = 1'b1;
        tick();
        bus0.dr_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp_a = 8'hFC + 8'((c - 1) / 2);
            if (c <= 8 && bus0.mem_addr !== exp_a) addr_bad++;
            if (bus0.dr_ready === 1'b1) begin done = c; break; end
            tick();
        end
        total++;
        if (addr_bad != 0) begin bad++; $display("FAIL w0_read_addr: %0d bad cycles want 0", addr_bad); end
        total++;
        if (done != 9 || bus0.dr_line !== c_line_e) begin
            bad++;
            $display("FAIL w0_read: cycle %0d line %h want 9 %h", done, bus0.dr_line, c_line_e);
        end
        tick();
        done = 0;
        bus0.dw_addr  = 8'h10;
        bus0.dw_line  = c_line_d;
        bus0.dw_valid = 1'b1;
        tick();
        bus0.dw_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus0.mem_we === 1'b1) begin
                if (c > 4 || bus0.mem_addr !== 8'(8'h10 + c - 1) || bus0.mem_wdata !== c_line_d[32*(c-1) +: 32]) we_bad++;
                np++;
            end
            if (bus0.dw_ready === 1'b1) begin done = c; break; end
            tick();
        end
        total++;
        if (np != 4 || we_bad != 0) begin bad++; $display("FAIL w0_write_pulses: n=%0d bad=%0d want 4/0", np, we_bad); end
        total++;
        if (done != 5) begin bad++; $display("FAIL w0_write_latency: cycle %0d want 5", done); end
        total++;
        if ({ram0.mem[19], ram0.mem[18], ram0.mem[17], ram0.mem[16]} !== c_line_d) begin
            bad++;
            $display("FAIL w0_ram: %h want %h", {ram0.mem[19], ram0.mem[18], ram0.mem[17], ram0.mem[16]}, c_line_d);
        end
        tick();
    endtask

    initial begin
        rstn          = 1'b0;
        bus.dr_valid  = 1'b0;
        bus.dr_addr   = 8'h00;
        bus.dw_valid  = 1'b0;
        bus.dw_addr   = 8'h00;
        bus.dw_line   = '0;
        bus0.dr_valid = 1'b0;
        bus0.dr_addr  = 8'h00;
        bus0.dw_valid = 1'b0;
        bus0.dw_addr  = 8'h00;
        bus0.dw_line  = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_wait0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
